commit_checker: RTL and testbench

- Synthesizable, parametrised golden-state checker that sits beside the ROB commit port.
- Each cycle it accepts up to NUM_LANES in-order retirements (pc, next_pc, rd write).
- It keeps a shadow architectural register file and an expected-PC tracker, and compares the shadow against the CPU regfile one cycle after each commit.
- It tracks a run/halt state and reports, counts and latches the first error. It replaces per-opcode re-execution with retirement-trace checking, so it works at any commit width.

---
 rtl/commit_checker.sv | 221 ++++++++++++++++++++++
 tb/tb_commit_checker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_checker.sv
// Golden-state retirement checker: shadows the architectural regfile and PC chain from the
// ROB commit port, compares against the CPU regfile, and reports/counts/latches errors.
module commit_checker #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     NUM_LANES   = 4,
  parameter int unsigned     NREGS       = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 'h60,
  parameter int unsigned     CNT_W       = 32,
  parameter bit              STOP_ON_ERR = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_LANES-1:0]                 cm_valid,
  input  logic [NUM_LANES*XLEN-1:0]            cm_pc,
  input  logic [NUM_LANES*XLEN-1:0]            cm_next_pc,
  input  logic [NUM_LANES-1:0]                 cm_rd_we,
  input  logic [NUM_LANES*$clog2(NREGS)-1:0]   cm_rd,
  input  logic [NUM_LANES*XLEN-1:0]            cm_rd_data,
  input  logic [NUM_LANES-1:0]                 cm_halt,
  input  logic                                 redirect,
  input  logic [XLEN-1:0]                      redirect_pc,
  input  logic [NREGS*XLEN-1:0]                cpu_regs,
  output logic                                 err_valid,
  output logic [2:0]                           err_code,
  output logic [$clog2(NREGS)-1:0]             err_reg,
  output logic [2:0]                           first_err_code,
  output logic [XLEN-1:0]                      first_err_pc,
  output logic [CNT_W-1:0]                     commit_count,
  output logic [CNT_W-1:0]                     err_count,
  output logic [1:0]                           state
);

  localparam int unsigned RW = $clog2(NREGS);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    E_NONE = 3'd0,
    E_PC   = 3'd1,
    E_REG  = 3'd2,
    E_GAP  = 3'd3,
    E_HALT = 3'd4
  } err_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   exp_pc_q, exp_pc_d;
  logic [XLEN-1:0]   shadow_q [NREGS];
  logic [XLEN-1:0]   shadow_d [NREGS];
  logic              cmp_pending_q, cmp_pending_d;
  logic              err_valid_q, err_valid_d;
  logic [2:0]        err_code_q, err_code_d;
  logic [RW-1:0]     err_reg_q, err_reg_d;
  logic [2:0]        first_err_code_q, first_err_code_d;
  logic [XLEN-1:0]   first_err_pc_q, first_err_pc_d;
  logic [CNT_W-1:0]  commit_count_q, commit_count_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  logic              in_prefix, live, any_take, halt_taken;
  logic              gap_err, hc_err, pc_err, reg_err;
  logic [XLEN-1:0]   gap_pc, hc_pc, pc_err_pc, chain, code_pc;
  logic [RW-1:0]     reg_idx;
  logic [CNT_W-1:0]  n_take;
  logic [2:0]        n_kinds;
  err_e              code;
  logic [CNT_W:0]    commit_sum, err_sum;

  always_comb begin
    state_d          = state_q;
    exp_pc_d         = exp_pc_q;
    shadow_d         = shadow_q;
    cmp_pending_d    = 1'b0;
    err_valid_d      = 1'b0;
    err_code_d       = E_NONE;
    err_reg_d        = '0;
    first_err_code_d = first_err_code_q;
    first_err_pc_d   = first_err_pc_q;
    commit_count_d   = commit_count_q;
    err_count_d      = err_count_q;
    in_prefix        = 1'b1;
    live             = (state_q == ST_RUN);
    any_take         = 1'b0;
    halt_taken       = 1'b0;
    gap_err          = 1'b0;
    hc_err           = 1'b0;
    pc_err           = 1'b0;
    reg_err          = 1'b0;
    gap_pc           = '0;
    hc_pc            = '0;
    pc_err_pc        = '0;
    chain            = exp_pc_q;
    code_pc          = '0;
    reg_idx          = '0;
    n_take           = '0;
    n_kinds          = '0;
    code             = E_NONE;
    commit_sum       = '0;
    err_sum          = '0;

    if (state_q != ST_ERROR) begin
      // Walk lanes in order: the contiguous valid prefix is processed until a halt lane
      // closes it; the first valid lane past a hole is the gap error.
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (cm_valid[i]) begin
          if (!in_prefix && !gap_err) begin
            gap_err = 1'b1;
            gap_pc  = cm_pc[i*XLEN +: XLEN];
          end
          if (in_prefix && live) begin
            if (!pc_err && (cm_pc[i*XLEN +: XLEN] != chain)) begin
              pc_err    = 1'b1;
              pc_err_pc = cm_pc[i*XLEN +: XLEN];
            end
            chain = cm_next_pc[i*XLEN +: XLEN];
            if (cm_rd_we[i] && (cm_rd[i*RW +: RW] != '0)) begin
              shadow_d[cm_rd[i*RW +: RW]] = cm_rd_data[i*XLEN +: XLEN];
            end
            n_take   = n_take + CNT_W'(1);
            any_take = 1'b1;
            if (cm_halt[i]) begin
              live       = 1'b0;
              halt_taken = 1'b1;
            end
          end
        end else begin
          in_prefix = 1'b0;
        end
      end

      for (int unsigned i = NUM_LANES; i > 0; i--) begin
        if (cm_valid[i-1]) hc_pc = cm_pc[(i-1)*XLEN +: XLEN];
      end
      hc_err = (state_q == ST_HALTED) && (|cm_valid);

      if (cmp_pending_q) begin
        for (int unsigned r = NREGS; r > 0; r--) begin
          if (cpu_regs[(r-1)*XLEN +: XLEN] != shadow_q[r-1]) begin
            reg_err = 1'b1;
            reg_idx = RW'(r - 1);
          end
        end
      end

      if (any_take) exp_pc_d = chain;
      if (redirect) exp_pc_d = redirect_pc;
      cmp_pending_d = |cm_valid;

      n_kinds = 3'(gap_err) + 3'(hc_err) + 3'(pc_err) + 3'(reg_err);
      if (gap_err) begin
        code    = E_GAP;
        code_pc = gap_pc;
      end else if (hc_err) begin
        code    = E_HALT;
        code_pc = hc_pc;
      end else if (pc_err) begin
        code    = E_PC;
        code_pc = pc_err_pc;
      end else if (reg_err) begin
        code    = E_REG;
        code_pc = exp_pc_q;
      end

      err_valid_d = (code != E_NONE);
      err_code_d  = code;
      err_reg_d   = (code == E_REG) ? reg_idx : '0;
      if ((first_err_code_q == 3'd0) && (code != E_NONE)) begin
        first_err_code_d = code;
        first_err_pc_d   = code_pc;
      end

      commit_sum     = {1'b0, commit_count_q} + {1'b0, n_take};
      commit_count_d = commit_sum[CNT_W] ? '1 : commit_sum[CNT_W-1:0];
      err_sum        = {1'b0, err_count_q} + {1'b0, CNT_W'(n_kinds)};
      err_count_d    = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];

      if (halt_taken) state_d = ST_HALTED;
      if (STOP_ON_ERR && (code != E_NONE)) state_d = ST_ERROR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= ST_RUN;
      exp_pc_q         <= RESET_PC;
      for (int unsigned r = 0; r < NREGS; r++) shadow_q[r] <= '0;
      cmp_pending_q    <= 1'b0;
      err_valid_q      <= 1'b0;
      err_code_q       <= '0;
      err_reg_q        <= '0;
      first_err_code_q <= '0;
      first_err_pc_q   <= '0;
      commit_count_q   <= '0;
      err_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      exp_pc_q         <= exp_pc_d;
      for (int unsigned r = 0; r < NREGS; r++) shadow_q[r] <= shadow_d[r];
      cmp_pending_q    <= cmp_pending_d;
      err_valid_q      <= err_valid_d;
      err_code_q       <= err_code_d;
      err_reg_q        <= err_reg_d;
      first_err_code_q <= first_err_code_d;
      first_err_pc_q   <= first_err_pc_d;
      commit_count_q   <= commit_count_d;
      err_count_q      <= err_count_d;
    end
  end

  assign err_valid      = err_valid_q;
  assign err_code       = err_code_q;
  assign err_reg        = err_reg_q;
  assign first_err_code = first_err_code_q;
  assign first_err_pc   = first_err_pc_q;
  assign commit_count   = commit_count_q;
  assign err_count      = err_count_q;
  assign state          = state_q;

endmodule

// File: tb/tb_commit_checker.sv
// Directed bench for commit_checker: two instances (STOP_ON_ERR 0 and 1) checked every cycle
// against a retirement-trace model, plus literal expectations pinning key scenarios.
module tb_commit_checker;
  localparam int XL = 32;
  localparam int NL = 4;
  localparam int NR = 32;
  localparam int RW = 5;
  localparam longint CMAX = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NL-1:0]       cm_valid, cm_rd_we, cm_halt;
  logic [NL*XL-1:0]    cm_pc, cm_next_pc, cm_rd_data;
  logic [NL*RW-1:0]    cm_rd;
  logic                redirect;
  logic [XL-1:0]       redirect_pc;
  logic [NR*XL-1:0]    cpu_regs;

  logic [1:0]          ev;
  logic [1:0][2:0]     ec;
  logic [1:0][RW-1:0]  er;
  logic [1:0][2:0]     fc;
  logic [1:0][XL-1:0]  fp;
  logic [1:0][31:0]    cc;
  logic [1:0][31:0]    ecn;
  logic [1:0][1:0]     st;

  commit_checker #(.STOP_ON_ERR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_next_pc(cm_next_pc),
    .cm_rd_we(cm_rd_we), .cm_rd(cm_rd), .cm_rd_data(cm_rd_data), .cm_halt(cm_halt),
    .redirect(redirect), .redirect_pc(redirect_pc), .cpu_regs(cpu_regs),
    .err_valid(ev[0]), .err_code(ec[0]), .err_reg(er[0]), .first_err_code(fc[0]),
    .first_err_pc(fp[0]), .commit_count(cc[0]), .err_count(ecn[0]), .state(st[0]));

  commit_checker #(.STOP_ON_ERR(1'b1)) dut1 (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_next_pc(cm_next_pc),
    .cm_rd_we(cm_rd_we), .cm_rd(cm_rd), .cm_rd_data(cm_rd_data), .cm_halt(cm_halt),
    .redirect(redirect), .redirect_pc(redirect_pc), .cpu_regs(cpu_regs),
    .err_valid(ev[1]), .err_code(ec[1]), .err_reg(er[1]), .first_err_code(fc[1]),
    .first_err_pc(fp[1]), .commit_count(cc[1]), .err_count(ecn[1]), .state(st[1]));

  // stimulus for the current cycle
  bit          v[4], we[4], hl[4];
  logic [31:0] pc[4], npc[4], dat[4];
  logic [4:0]  rd[4];
  bit          rdir;
  logic [31:0] rpc;
  logic [31:0] cpu[32];

  // model state, index 0 = continue-on-error, 1 = stop-on-error
  logic [31:0] m_regs[2][32];
  logic [31:0] m_exp[2], m_fp[2];
  int          m_st[2], m_ec[2], m_er[2], m_fc[2];
  bit          m_pend[2], m_ev[2];
  longint      m_cc[2], m_ecn[2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int m);
    int n_ok, take, code, kinds, rr;
    bit gap, hc, pe, re, any;
    logic [31:0] gap_pc, hc_pc, pe_pc, chain, old_exp, cpc;
    if (!rst) begin
      for (int r = 0; r < 32; r++) m_regs[m][r] = '0;
      m_exp[m] = 32'h60; m_st[m] = 0; m_pend[m] = 0; m_ev[m] = 0; m_ec[m] = 0; m_er[m] = 0;
      m_fc[m] = 0; m_fp[m] = '0; m_cc[m] = 0; m_ecn[m] = 0;
      return;
    end
    if (m_st[m] == 2) begin
      m_ev[m] = 0; m_ec[m] = 0; m_er[m] = 0; m_pend[m] = 0;
      return;
    end
    n_ok = 0;
    while (n_ok < 4 && v[n_ok]) n_ok++;
    gap = 0; gap_pc = '0;
    for (int i = n_ok; i < 4; i++) if (v[i] && !gap) begin gap = 1; gap_pc = pc[i]; end
    any = 0; hc_pc = '0;
    for (int i = 3; i >= 0; i--) if (v[i]) begin any = 1; hc_pc = pc[i]; end
    hc = (m_st[m] == 1) && any;
    take = 0;
    if (m_st[m] == 0) begin
      for (int i = 0; i < n_ok; i++) begin
        take = i + 1;
        if (hl[i]) break;
      end
    end
    pe = 0; pe_pc = '0; chain = m_exp[m];
    for (int i = 0; i < take; i++) begin
      if (!pe && pc[i] != chain) begin pe = 1; pe_pc = pc[i]; end
      chain = npc[i];
    end
    re = 0; rr = 0;
    if (m_pend[m]) for (int r = 0; r < 32; r++) if (!re && cpu[r] !== m_regs[m][r]) begin re = 1; rr = r; end
    old_exp = m_exp[m];
    for (int i = 0; i < take; i++) if (we[i] && rd[i] != 0) m_regs[m][rd[i]] = dat[i];
    if (take > 0) m_exp[m] = chain;
    if (rdir) m_exp[m] = rpc;
    m_cc[m] = (m_cc[m] + take > CMAX) ? CMAX : m_cc[m] + take;
    kinds = int'(gap) + int'(hc) + int'(pe) + int'(re);
    m_ecn[m] = (m_ecn[m] + kinds > CMAX) ? CMAX : m_ecn[m] + kinds;
    code = 0; cpc = '0;
    if (gap) begin code = 3; cpc = gap_pc; end
    else if (hc) begin code = 4; cpc = hc_pc; end
    else if (pe) begin code = 1; cpc = pe_pc; end
    else if (re) begin code = 2; cpc = old_exp; end
    m_ev[m] = (kinds > 0); m_ec[m] = code; m_er[m] = (code == 2) ? rr : 0;
    if (m_fc[m] == 0 && code != 0) begin m_fc[m] = code; m_fp[m] = cpc; end
    m_pend[m] = any;
    if (m_st[m] == 0 && take > 0 && hl[take-1]) m_st[m] = 1;
    if (m == 1 && kinds > 0) m_st[m] = 2;
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      v[i] = 0; we[i] = 0; hl[i] = 0; pc[i] = '0; npc[i] = '0; dat[i] = '0; rd[i] = '0;
    end
    rdir = 0; rpc = '0;
    for (int r = 0; r < 32; r++) cpu[r] = m_regs[0][r];
  endtask

  task automatic lane(input int i, input logic [31:0] p, input logic [31:0] n, input bit w,
                      input logic [4:0] r, input logic [31:0] d, input bit h);
    v[i] = 1; pc[i] = p; npc[i] = n; we[i] = w; rd[i] = r; dat[i] = d; hl[i] = h;
  endtask

  task automatic step();
    for (int i = 0; i < 4; i++) begin
      cm_valid[i] = v[i]; cm_rd_we[i] = we[i]; cm_halt[i] = hl[i];
      cm_pc[i*XL +: XL] = pc[i]; cm_next_pc[i*XL +: XL] = npc[i];
      cm_rd_data[i*XL +: XL] = dat[i]; cm_rd[i*RW +: RW] = rd[i];
    end
    redirect = rdir; redirect_pc = rpc;
    for (int r = 0; r < 32; r++) cpu_regs[r*XL +: XL] = cpu[r];
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("d%0d.err_valid", m), 64'(ev[m]), 64'(m_ev[m]));
      chk($sformatf("d%0d.err_code", m), 64'(ec[m]), 64'(m_ec[m]));
      chk($sformatf("d%0d.err_reg", m), 64'(er[m]), 64'(m_er[m]));
      chk($sformatf("d%0d.first_err_code", m), 64'(fc[m]), 64'(m_fc[m]));
      chk($sformatf("d%0d.first_err_pc", m), 64'(fp[m]), 64'(m_fp[m]));
      chk($sformatf("d%0d.commit_count", m), 64'(cc[m]), 64'(m_cc[m]));
      chk($sformatf("d%0d.err_count", m), 64'(ecn[m]), 64'(m_ecn[m]));
      chk($sformatf("d%0d.state", m), 64'(st[m]), 64'(m_st[m]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int m = 0; m < 2; m++) for (int r = 0; r < 32; r++) m_regs[m][r] = '0;
    rst = 0;
    clr(); step(); step();
    chk("lit.reset_state", 64'(st[0]), 64'd0);
    chk("lit.reset_commit_count", 64'(cc[0]), 64'd0);
    chk("lit.reset_err_valid", 64'(ev[0]), 64'd0);
    chk("lit.reset_first_err_code", 64'(fc[0]), 64'd0);
    rst = 1;

    // single commit, regfile agrees next cycle
    clr(); lane(0, 32'h60, 32'h64, 1, 5'd1, 32'd5, 0); step();
    clr(); step();
    chk("lit.first_commit_count", 64'(cc[0]), 64'd1);
    chk("lit.first_commit_no_err", 64'(ev[0]), 64'd0);

    // full-width cycle
    clr();
    for (int i = 0; i < 4; i++) lane(i, 32'h64 + 4*i, 32'h68 + 4*i, 0, 5'd0, 32'd0, 0);
    step();
    chk("lit.four_lane_count", 64'(cc[0]), 64'd5);
    clr(); step();

    // redirect to 0x80 then commit at 0x64 -> pc error
    clr(); rdir = 1; rpc = 32'h80; step();
    clr(); lane(0, 32'h64, 32'h68, 0, 5'd0, 32'd0, 0); step();
    chk("lit.pc_err_valid", 64'(ev[0]), 64'd1);
    chk("lit.pc_err_code", 64'(ec[0]), 64'd1);
    chk("lit.pc_first_err_pc", 64'(fp[0]), 64'h64);
    chk("lit.stop_state_error", 64'(st[1]), 64'd2);
    clr(); lane(0, 32'h68, 32'h6c, 0, 5'd0, 32'd0, 0); step();
    chk("lit.resync_no_err", 64'(ev[0]), 64'd0);
    chk("lit.stop_err_count_frozen", 64'(ecn[1]), 64'd1);
    chk("lit.stop_commit_frozen", 64'(cc[1]), 64'd6);

    // same rd in lanes 1 and 3: highest lane wins; cpu shows the lower-lane value
    clr();
    lane(0, 32'h6c, 32'h70, 0, 5'd0, 32'd0, 0);
    lane(1, 32'h70, 32'h74, 1, 5'd7, 32'h11, 0);
    lane(2, 32'h74, 32'h78, 0, 5'd0, 32'd0, 0);
    lane(3, 32'h78, 32'h7c, 1, 5'd7, 32'h22, 0);
    step();
    chk("lit.reg_err_not_early", 64'(ev[0]), 64'd0);
    clr(); cpu[7] = 32'h11; step();
    chk("lit.reg_err_code", 64'(ec[0]), 64'd2);
    chk("lit.reg_err_reg", 64'(er[0]), 64'd7);
    clr(); step();

    // x0 write dropped
    clr(); lane(0, 32'h7c, 32'h80, 1, 5'd0, 32'hdead, 0); step();
    clr(); step();
    chk("lit.x0_no_err", 64'(ev[0]), 64'd0);

    // lane gap: lane0 processed, lane2 ignored
    clr();
    lane(0, 32'h80, 32'h84, 1, 5'd2, 32'h33, 0);
    lane(2, 32'h999, 32'h99d, 1, 5'd3, 32'h44, 0);
    step();
    chk("lit.gap_code", 64'(ec[0]), 64'd3);
    clr(); step();

    // halt on lane1, lanes above ignored
    clr();
    lane(0, 32'h84, 32'h88, 0, 5'd0, 32'd0, 0);
    lane(1, 32'h88, 32'h8c, 1, 5'd4, 32'h55, 1);
    lane(2, 32'h8c, 32'h90, 1, 5'd5, 32'h66, 0);
    lane(3, 32'h90, 32'h94, 0, 5'd0, 32'd0, 0);
    step();
    chk("lit.halted_state", 64'(st[0]), 64'd1);
    chk("lit.halted_count", 64'(cc[0]), 64'd15);
    clr(); step();

    // commit after halt
    clr(); lane(0, 32'h200, 32'h204, 1, 5'd6, 32'h77, 0); step();
    chk("lit.after_halt_code", 64'(ec[0]), 64'd4);
    chk("lit.after_halt_count", 64'(cc[0]), 64'd15);
    chk("lit.after_halt_errs", 64'(ecn[0]), 64'd4);

    // gap + commit-after-halt + reg mismatch together: 3 reported, 3 counted
    clr(); cpu[5] = 32'hbad;
    lane(0, 32'h300, 32'h304, 0, 5'd0, 32'd0, 0);
    lane(2, 32'h308, 32'h30c, 0, 5'd0, 32'd0, 0);
    step();
    chk("lit.multi_code", 64'(ec[0]), 64'd3);
    chk("lit.multi_errs", 64'(ecn[0]), 64'd7);

    // reset while a compare is pending
    clr(); cpu[5] = 32'hbad; rst = 0; step();
    chk("lit.mid_reset_count", 64'(cc[0]), 64'd0);
    chk("lit.mid_reset_first", 64'(fc[0]), 64'd0);
    rst = 1;
    clr(); cpu[5] = 32'hbad; step();
    chk("lit.no_stale_err", 64'(ev[0]), 64'd0);

    // redirect in same cycle as a commit: commit checked against old chain
    clr(); lane(0, 32'h60, 32'h64, 1, 5'd9, 32'h99, 0); rdir = 1; rpc = 32'h300; step();
    chk("lit.redirect_commit_ok", 64'(ev[0]), 64'd0);
    clr(); lane(0, 32'h300, 32'h304, 0, 5'd0, 32'd0, 0); step();
    chk("lit.redirect_target_ok", 64'(ev[0]), 64'd0);
    clr(); step();
    clr(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
